div_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32M divide group (DIV, DIVU, REM, REMU), placed beside the single-cycle ALU in the execute stage. It accepts one divide operation, runs a radix-2 restoring shift-subtract loop and applies sign correction. It also holds the pipeline stalled until the result is ready. Results are written back through the same execute-stage result mux as ALU results.

---
 rtl/div_sequencer.sv | 172 +++++++++++++++++
 tb/tb_div_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU) for the
// execute stage. Radix-2 restoring shift-subtract on operand magnitudes,
// followed by a single sign-fix cycle. Divide-by-zero and signed overflow
// are resolved at accept time and skip the iteration loop.
//
// Handshake: an operation is accepted on a rising edge when the unit is
// IDLE, start is high, funct3[2] is high and flush is low; operands and
// funct3 are sampled on that edge. stall is high in the accept cycle and
// through CALC/FIX so the pipeline holds the instruction. done pulses for
// exactly one cycle (DONE state) with result already valid and stall low,
// so the pipeline captures result in that cycle. flush abandons any
// operation without a done pulse and leaves result untouched.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       o_dbg_state
);

    // Iteration counter is 5 bits for the RV32 case; widened only if WIDTH
    // ever exceeds 32.
    localparam int CNT_W = (WIDTH > 32) ? $clog2(WIDTH) : 5;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_is_rem;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_res;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_sub;
    logic               w_ge;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Accept decode, operand magnitudes and special-case detection.
    always_comb begin
        w_accept      = (r_state == S_IDLE) && start && funct3[2] && !flush;
        w_signed      = !funct3[0];
        w_a_neg       = w_signed && dividend[WIDTH-1];
        w_b_neg       = w_signed && divisor[WIDTH-1];
        w_a_mag       = w_a_neg ? -dividend : dividend;
        w_b_mag       = w_b_neg ? -divisor : divisor;
        w_div_zero    = (divisor == '0);
        w_ovf         = w_signed && (dividend == MIN_NEG) && (divisor == '1);
        w_special     = w_div_zero || w_ovf;
        if (w_div_zero) begin
            w_special_res = funct3[1] ? dividend : '1;
        end else begin
            w_special_res = funct3[1] ? '0 : MIN_NEG;
        end
    end

    // One restoring step and the sign-fix values. The remainder's top bit
    // is always zero after a step; folding it into the compare keeps the
    // step well defined for any register content.
    always_comb begin
        w_shift   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
        w_sub     = w_shift - {1'b0, r_dvs};
        w_ge      = r_rem[WIDTH] || (w_shift >= {1'b0, r_dvs});
        w_quo_fix = r_neg_q ? -r_quo : r_quo;
        w_rem_fix = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and status outputs; flush overrides every transition.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        stall  = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush) begin
            w_next = S_IDLE;
        end
        busy  = (r_state != S_IDLE);
        stall = (r_state == S_CALC) || (r_state == S_FIX) || w_accept;
        done  = (r_state == S_DONE);
    end

    // Datapath: operand load on accept, shift-subtract in CALC, sign fix
    // and result load in FIX. A flush freezes everything in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_rem    <= '0;
            r_quo    <= w_a_mag;
            r_dvs    <= w_b_mag;
            r_is_rem <= funct3[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (!flush && (r_state == S_CALC)) begin
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_rem <= w_ge ? w_sub : w_shift;
            r_cnt <= r_cnt - 1'b1;
        end else if (!flush && (r_state == S_FIX)) begin
            r_result <= r_is_rem ? w_rem_fix : w_quo_fix;
        end
    end

    assign result      = r_result;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed and randomized checks of div_sequencer against
// an arithmetic reference (RV32M semantics) and a cycle-age timeline model.
module tb_div_sequencer;

  localparam int W = 32;
  localparam int NORM_LAT = W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         start;
  logic [2:0]   funct3;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         flush;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  div_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .funct3      (funct3),
    .dividend    (dividend),
    .divisor     (divisor),
    .flush       (flush),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .result      (result),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_div(input logic [2:0] f3, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (b == 0) return f3[1] ? a : {W{1'b1}};
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return f3[1] ? 32'h0 : 32'h8000_0000;
    if (!f3[0]) return f3[1] ? W'(sa % sb) : W'(sa / sb);
    return f3[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return NORM_LAT;
  endfunction

  // Timeline model: m_age counts cycles since accept (0 = idle); done is
  // expected in the cycle where m_age equals m_lat.
  int           m_age = 0;
  int           m_lat = 0;
  logic [W-1:0] m_pend = '0;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age = 0;
      m_res = '0;
      exp_q.delete();
    end else if (flush) begin
      if (m_age != 0 && m_age < m_lat && exp_q.size() > 0) void'(exp_q.pop_back());
      m_age = 0;
    end else if (m_age == 0) begin
      if (start && funct3[2]) begin
        m_pend = ref_div(funct3, dividend, divisor);
        m_lat  = ref_lat(funct3, dividend, divisor);
        exp_q.push_back(m_pend);
        m_age = 1;
        if (m_lat == 1) m_res = m_pend;
      end
    end else if (m_age == m_lat) begin
      m_age = 0;
    end else begin
      m_age++;
      if (m_age == m_lat) m_res = m_pend;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic         acc_now;
    logic         e_busy;
    logic         e_stall;
    logic         e_done;
    logic [W-1:0] e_r;
    if (rst_n === 1'b1) begin
      acc_now = (m_age == 0) && start && funct3[2] && !flush;
      e_busy  = (m_age != 0);
      e_done  = (m_age != 0) && (m_age == m_lat);
      e_stall = ((m_age != 0) && (m_age < m_lat)) || acc_now;
      chk("busy", busy, e_busy);
      chk("stall", stall, e_stall);
      chk("done", done, e_done);
      chk("result_hold", result, m_res);
      if (e_done) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_empty", 1, 0);
        end else begin
          e_r = exp_q.pop_front();
          chk("done_result", result, e_r);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    funct3   = f3;
    dividend = a;
    divisor  = b;
    step();
    start = 1'b0;
  endtask

  // Returns the cycle (1 = first cycle after accept) in which done was seen,
  // then advances one more cycle so the unit is idle again.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    if (done !== 1'b1) chk("done_timeout", 0, 1);
    step();
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] exp_r);
    int lat;
    issue(f3, a, b);
    wait_done(lat);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_res"}, result, exp_r);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int k;
    int saw;
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] held;

    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    funct3 = 3'b000;
    dividend = '0;
    divisor = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Pin the reference model to hand-computed values.
    chk("ref_divu", ref_div(3'b101, 100, 7), 32'd14);
    chk("ref_rem_neg", ref_div(3'b110, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
    chk("ref_div_neg", ref_div(3'b100, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
    chk("ref_div0", ref_div(3'b100, 5, 0), 32'hFFFF_FFFF);
    chk("ref_remu0", ref_div(3'b111, 5, 0), 32'd5);
    chk("ref_ovf_q", ref_div(3'b100, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("ref_ovf_r", ref_div(3'b110, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);

    // DIVU 100 / 7: stall in the accept cycle, done at 34, busy drops after.
    start = 1'b1; funct3 = 3'b101; dividend = 100; divisor = 7;
    #1;
    chk("accept_stall", stall, 1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    chk("divu_lat", lat, 34);
    chk("divu_res", result, 32'd14);
    chk("divu_busy_after", busy, 0);

    run_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 2, 34, 32'hFFFF_FFFF);
    run_op("div_neg", 3'b100, 32'hFFFF_FFF9, 2, 34, 32'hFFFF_FFFD);
    run_op("div_zero", 3'b100, 5, 0, 1, 32'hFFFF_FFFF);
    run_op("remu_zero", 3'b111, 5, 0, 1, 32'd5);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0);

    // Flush at CALC cycle 10, then an immediate new op.
    held = result;
    issue(3'b101, 1000, 3);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_stall", stall, 0);
    chk("flush_done", done, 0);
    chk("flush_result", result, held);
    run_op("after_flush", 3'b101, 9, 3, 34, 32'd3);

    // Start while busy is ignored.
    issue(3'b101, 50, 5);
    start = 1'b1; funct3 = 3'b100; dividend = 7; divisor = 0;
    repeat (3) step();
    start = 1'b0;
    wait_done(lat);
    chk("busy_start_res", result, 32'd10);

    // funct3[2]=0 and start-with-flush are both ignored.
    issue(3'b001, 20, 4);
    chk("nondiv_busy", busy, 0);
    flush = 1'b1;
    issue(3'b101, 20, 4);
    flush = 1'b0;
    chk("flush_wins_busy", busy, 0);

    // Asynchronous reset mid-CALC.
    issue(3'b101, 1000, 10);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_stall", stall, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) saw = 1;
      step();
    end
    chk("arst_no_done", saw, 0);

    // Randomized operations with occasional flushes and ignored requests.
    for (int n = 0; n < 160; n++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 20);
        2: a = -$urandom_range(1, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0: b = 0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        3: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0: issue(3'($urandom_range(0, 3)), a, b);
        1: begin
          issue(f3, a, b);
          k = $urandom_range(0, 36);
          repeat (k) step();
          flush = 1'b1;
          step();
          flush = 1'b0;
        end
        default: begin
          issue(f3, a, b);
          wait_done(lat);
          chk("rnd_lat", lat, ref_lat(f3, a, b));
        end
      endcase
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
